// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared state types and constants for the UART SRAM transmit path and the
// top-level state machine that muxes it onto the SRAM controller.
package uart_sram_tx_interface_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int SRAM_READ_LATENCY_DEFAULT = 2;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE_UART_RX,
    S_WAIT_UART_RX,
    S_UART_TX
  } top_state_type;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_NEXT
  } tx_state_type;

  // 18-bit address arithmetic wraps naturally at 2^18.
  function automatic logic [SRAM_ADDR_W-1:0] next_sram_address(input logic [SRAM_ADDR_W-1:0] a);
    return a + 18'd1;
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_uart_tx.sv
// UART_transmit_controller: 8N1 byte serializer. A new TX_start is accepted
// while idle or in the final stop-bit cycle, so consecutive bytes abut.
module uart_sram_tx_interface_uart_tx
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] TX_data,
  input  logic       TX_start,
  output logic       TX_busy,
  output logic       TX_byte_done,
  output logic       UART_TX_O
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign bit_end      = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign TX_byte_done = busy_q && bit_end && (bit_q == 4'd9);
  assign TX_busy      = busy_q;
  // Bit 0 of the shift register is the line itself; idle keeps it all ones.
  assign UART_TX_O    = shift_q[0];

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    if (busy_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d  = 1'b0;
          bit_d   = 4'd0;
          shift_d = '1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
    if (TX_start && (!busy_q || TX_byte_done)) begin
      shift_d = {1'b1, TX_data, 1'b0};
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = 4'd0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each as two UART frames,
// high byte first, pulsing Done after the last stop bit.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = UART_CLKS_PER_BIT_115200,
  parameter int SRAM_READ_LATENCY = SRAM_READ_LATENCY_DEFAULT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int LW = $clog2(SRAM_READ_LATENCY + 1);

  tx_state_type  state_q, state_d;
  logic [17:0]   addr_q, addr_d;
  logic [17:0]   remaining_q, remaining_d;
  logic [7:0]    lo_byte_q, lo_byte_d;
  logic [LW-1:0] wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_byte_done;

  uart_sram_tx_interface_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .TX_data     (tx_data),
    .TX_start    (tx_start),
    .TX_busy     (tx_busy),
    .TX_byte_done(tx_byte_done),
    .UART_TX_O   (UART_TX_O)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lo_byte_d   = lo_byte_q;
    wait_d      = wait_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_start    = 1'b0;
    tx_data     = lo_byte_q;
    unique case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          if (Word_count == 18'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = Start_address;
            remaining_d = Word_count;
            busy_d      = 1'b1;
            wait_d      = '0;
            state_d     = S_TX_READ;
          end
        end
      end
      S_TX_READ: begin
        // High byte goes straight from the SRAM bus; only the low byte is kept.
        if (wait_q == LW'(SRAM_READ_LATENCY)) begin
          if (!tx_busy) begin
            lo_byte_d = SRAM_read_data[7:0];
            tx_data   = SRAM_read_data[15:8];
            tx_start  = 1'b1;
            state_d   = S_TX_SEND_HI;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_TX_SEND_HI: begin
        if (tx_byte_done) begin
          tx_start = 1'b1;
          tx_data  = lo_byte_q;
          state_d  = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        if (tx_byte_done) begin
          done_d  = (remaining_q == 18'd1);
          state_d = S_TX_NEXT;
        end
      end
      S_TX_NEXT: begin
        remaining_d = remaining_q - 18'd1;
        addr_d      = next_sram_address(addr_q);
        wait_d      = '0;
        if (remaining_q == 18'd1) begin
          busy_d  = 1'b0;
          state_d = S_TX_IDLE;
        end else begin
          state_d = S_TX_READ;
        end
      end
      default: state_d = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_TX_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      lo_byte_q   <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lo_byte_q   <= lo_byte_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = 16'd0;
  assign SRAM_we_n       = 1'b1;
  assign Busy            = busy_q;
  assign Done            = done_q;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: SRAM model with read latency, a UART line
// decoder and a transfer-level reference model checked every cycle.
module tb_uart_sram_tx_interface;

  localparam int CPB   = 32;
  localparam int LAT   = 2;
  localparam int FRAME = 10 * CPB;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  logic [15:0] mem [0:262143];
  logic [15:0] rd_p1, rd_p2;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 Clock = ~Clock;

  uart_sram_tx_interface #(
    .CLKS_PER_BIT(CPB),
    .SRAM_READ_LATENCY(LAT)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .Start_address  (Start_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  // SRAM: data for the address presented in cycle t is valid in cycle t+LAT.
  always @(posedge Clock) begin
    rd_p1 <= mem[SRAM_address];
    rd_p2 <= rd_p1;
  end
  assign SRAM_read_data = rd_p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + monitor state ----------------
  bit          busy_m, busy_before, exp_done, hi_next, was_hi, in_frame, bit_bad, skip_frame, zero_pend;
  int          done_due = -1;
  int          last_done_cyc = -1;
  int          gap_lim = -1;
  int          gap_cnt, frame_pos, fb;
  logic [9:0]  frame;
  logic [7:0]  rx_byte;
  logic [17:0] zero_ref, tmp_a;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_log[$];
  logic [17:0] exp_addr[$];
  logic [17:0] seen_addr[$];
  logic [17:0] last_addr_log[$];

  always @(negedge Clock) begin
    if (!Resetn) begin
      busy_m = 0; done_due = -1; in_frame = 0; gap_lim = -1; zero_pend = 0;
      exp_q.delete(); exp_addr.delete(); seen_addr.delete();
    end else begin
      busy_before = busy_m;
      exp_done = (cyc == done_due);
      chk("ctrl{busy,done,we_n,wdata}", {13'd0, Busy, Done, SRAM_we_n, SRAM_write_data},
          {13'd0, busy_before, exp_done, 1'b1, 16'h0000});
      if (Done === 1'b1) last_done_cyc = cyc;
      if (Busy === 1'b1 && (seen_addr.size() == 0 || seen_addr[$] != SRAM_address))
        seen_addr.push_back(SRAM_address);
      if (exp_done) begin
        chk("addr_count", seen_addr.size(), exp_addr.size());
        foreach (exp_addr[i]) if (i < seen_addr.size()) chk("addr_seq", seen_addr[i], exp_addr[i]);
        if (zero_pend) chk("zero_addr_hold", SRAM_address, zero_ref);
        last_addr_log = seen_addr;
        seen_addr.delete(); exp_addr.delete();
        zero_pend = 0; busy_m = 0; done_due = -1;
      end
      if (Start && !busy_before) begin
        if (Word_count == 18'd0) begin
          done_due = cyc + 1; zero_pend = 1; zero_ref = SRAM_address;
        end else begin
          busy_m = 1; hi_next = 1;
          for (int i = 0; i < int'(Word_count); i++) begin
            tmp_a = Start_address + 18'(i);
            exp_addr.push_back(tmp_a);
            exp_q.push_back(mem[tmp_a][15:8]);
            exp_q.push_back(mem[tmp_a][7:0]);
          end
        end
      end
      // UART line decoder / checker
      if (in_frame) begin
        fb = frame_pos / CPB;
        if (UART_TX_O !== frame[fb]) bit_bad = 1;
        if (fb >= 1 && fb <= 8 && (frame_pos % CPB) == CPB / 2) rx_byte[fb-1] = UART_TX_O;
        if ((frame_pos % CPB) == CPB - 1) begin
          if (!skip_frame) chk($sformatf("line_bit%0d_hold", fb), {31'd0, bit_bad}, 32'd0);
          bit_bad = 0;
        end
        frame_pos++;
        if (frame_pos == FRAME) begin
          in_frame = 0;
          rx_log.push_back(rx_byte);
          gap_cnt = 0;
          if (skip_frame) gap_lim = -1;
          else if (was_hi) gap_lim = 0;
          else if (exp_q.size() > 0) gap_lim = LAT + 4;
          else begin gap_lim = -1; done_due = cyc + 1; end
        end
      end else if (UART_TX_O === 1'b0) begin
        if (gap_lim >= 0) chk("gap_within_limit", {31'd0, gap_cnt <= gap_lim}, 32'd1);
        gap_lim = -1;
        skip_frame = (exp_q.size() == 0);
        if (skip_frame) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_frame cyc=%0d: got start bit expected idle line", cyc);
          frame = '1;
        end else begin
          frame = {1'b1, exp_q.pop_front(), 1'b0};
          was_hi = hi_next; hi_next = !hi_next;
        end
        in_frame = 1; frame_pos = 1; bit_bad = 0; rx_byte = '0;
      end else if (gap_lim >= 0) begin
        gap_cnt++;
        if (gap_cnt > gap_lim) begin
          chk("gap_within_limit", {31'd0, gap_cnt <= gap_lim}, 32'd1);
          gap_lim = -1;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic do_xfer(input logic [17:0] a, input logic [17:0] n, input bit dup, output int lat);
    int s;
    int budget;
    rx_log.delete();
    @(posedge Clock); #1;
    Start_address = a; Word_count = n; Start = 1'b1; s = cyc;
    @(posedge Clock); #1;
    Start = 1'b0; Start_address = 18'($urandom); Word_count = 18'($urandom_range(1, 7));
    if (dup) begin
      repeat (FRAME + FRAME / 2) @(posedge Clock);
      #1 Start = 1'b1;
      @(posedge Clock); #1 Start = 1'b0;
    end
    budget = (int'(n) + 1) * (2 * FRAME + LAT + 10) + 20;
    while (last_done_cyc <= s && budget > 0) begin
      @(posedge Clock);
      budget--;
    end
    if (last_done_cyc <= s) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout addr=%05h words=%0d: got no Done expected one", a, n);
    end
    lat = last_done_cyc - s;
    repeat (LAT + 8) @(posedge Clock);
    chk("byte_count", rx_log.size(), 2 * int'(n));
    $display("xfer addr=%05h words=%0d dup=%0d done_latency=%0d bytes=%0d", a, n, dup, lat, rx_log.size());
  endtask

  int lat;
  int guard;
  int rd_cnt;
  logic [17:0] ra, rn;

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
    mem[18'h00010] = 16'hA53C;
    mem[18'h00100] = 16'h0001;
    mem[18'h00101] = 16'h0203;
    mem[18'h00102] = 16'h0405;

    repeat (3) @(posedge Clock);
    #1;
    chk("rst_tx", {31'd0, UART_TX_O}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_addr", {14'd0, SRAM_address}, 32'd0);
    chk("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    Resetn = 1'b1;
    repeat (5) @(posedge Clock);

    // Single word 0xA53C
    do_xfer(18'h00010, 18'd1, 1'b0, lat);
    if (rx_log.size() == 2) begin
      chk("single_hi", {24'd0, rx_log[0]}, 32'h0A5);
      chk("single_lo", {24'd0, rx_log[1]}, 32'h03C);
    end
    chk("single_latency_ok", {31'd0, (lat >= 2 * FRAME + 1) && (lat <= 2 * FRAME + LAT + 6)}, 32'd1);
    chk("single_addr_n", last_addr_log.size(), 1);
    if (last_addr_log.size() == 1) chk("single_addr", {14'd0, last_addr_log[0]}, 32'h10);

    // Block of three words
    do_xfer(18'h00100, 18'd3, 1'b0, lat);
    for (int i = 0; i < 6; i++)
      if (i < rx_log.size()) chk($sformatf("block_byte%0d", i), {24'd0, rx_log[i]}, 32'(i));

    // Zero count
    do_xfer(18'h01234, 18'd0, 1'b0, lat);
    chk("zero_latency", lat, 1);

    // Address wrap
    do_xfer(18'h3FFFF, 18'd2, 1'b0, lat);
    chk("wrap_addr_n", last_addr_log.size(), 2);
    if (last_addr_log.size() == 2) begin
      chk("wrap_addr0", {14'd0, last_addr_log[0]}, 32'h3FFFF);
      chk("wrap_addr1", {14'd0, last_addr_log[1]}, 32'h00000);
    end

    // Start while busy, during the second frame
    do_xfer(18'h00100, 18'd2, 1'b1, lat);
    if (rx_log.size() == 4) chk("busy_start_byte3", {24'd0, rx_log[3]}, 32'h03);

    // Reset during a start bit
    @(posedge Clock); #1;
    Start_address = 18'h00020; Word_count = 18'd2; Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
    guard = 0;
    while (UART_TX_O !== 1'b0 && guard < 50) begin
      @(posedge Clock); #1;
      guard++;
    end
    #2 Resetn = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, UART_TX_O}, 32'd1);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_done", {31'd0, Done}, 32'd0);
    rd_cnt = last_done_cyc;
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;
    repeat (3 * FRAME) @(posedge Clock);
    chk("midrst_no_done", last_done_cyc, rd_cnt);
    $display("xfer reset-abort addr=00020 words=2 line=%0d busy=%0d", UART_TX_O, Busy);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? 18'h3FFFF - 18'($urandom_range(0, 2)) : 18'($urandom);
      rn = 18'($urandom_range(0, 3));
      do_xfer(ra, rn, (rn != 0) && ($urandom_range(0, 1) == 1), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(10 * 80000);
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish within 80000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
